puf_measure_ctrl: RTL and testbench
===================================

PUF_MEASURE_CTRL -- requirements
Module: puf_measure_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 12: width of each ring-oscillator count input.
REQ-002 SHALL have parameter CLR_CYCLES, default 2: number of cycles cnt_clr is asserted (legal range 1..15).
REQ-003 SHALL have parameter WINDOW_CYCLES, default 1024: number of cycles cnt_en is asserted (legal range 1..65535).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 4: number of idle cycles after the window before sampling (legal range 1..15).
REQ-005 SHALL have port clk, input, 1: system clock; all state changes on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: request one measurement; sampled only in IDLE.
REQ-008 SHALL have port abort, input, 1: cancel the measurement in progress.
REQ-009 SHALL have port cnt_a, input, CNT_W: count from ring-oscillator counter A.
REQ-010 SHALL have port cnt_b, input, CNT_W: count from ring-oscillator counter B.
REQ-011 SHALL have port cnt_clr, output, 1: active-high clear to both counters.
REQ-012 SHALL have port cnt_en, output, 1: count enable to both counters.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when results are valid.
REQ-015 SHALL have port resp_bit, output, 1: PUF response, 1 when cnt_a > cnt_b.
REQ-016 SHALL have port margin, output, CNT_W: absolute difference |cnt_a - cnt_b|.
REQ-017 SHALL have port tie, output, 1: high when cnt_a == cnt_b.
REQ-018 SHALL have port sat, output, 1: high when either count equals 2^CNT_W-1.

Function
REQ-019 SHALL implement FSM states IDLE, CLEAR, COUNT, SETTLE, COMPARE, DONE; all outputs registered.
REQ-020 IDLE -> CLEAR on the edge sampling start=1; start in any other state SHALL be ignored, with no queuing.
REQ-021 CLEAR SHALL assert cnt_clr for exactly CLR_CYCLES cycles, with cnt_en=0, then go to COUNT.
REQ-022 COUNT SHALL assert cnt_en for exactly WINDOW_CYCLES consecutive cycles, with cnt_clr=0, then go to SETTLE.
REQ-023 SETTLE SHALL hold cnt_en=0 and cnt_clr=0 for exactly SETTLE_CYCLES cycles, then go to COMPARE.
REQ-024 COMPARE SHALL latch cnt_a and cnt_b in one cycle and compute resp_bit, margin, tie and sat from the latched values.
REQ-025 DONE SHALL assert done for one cycle with results valid, then return to IDLE.
REQ-026 If start is sampled on edge 0, done SHALL be high in cycle CLR_CYCLES+WINDOW_CYCLES+SETTLE_CYCLES+2.
REQ-027 margin SHALL be computed unsigned without wrap: larger count minus smaller count.
REQ-028 On a tie, resp_bit SHALL be 0, tie SHALL be 1 and margin SHALL be 0.
REQ-029 resp_bit, margin, tie and sat SHALL hold their values until the next COMPARE; abort SHALL not alter them.
REQ-030 abort=1 in CLEAR, COUNT or SETTLE SHALL force IDLE on the next edge, with cnt_en=0, cnt_clr=0 and no done pulse.
REQ-031 abort in COMPARE, DONE or IDLE SHALL be ignored.
REQ-032 If abort and start are both high in IDLE, start SHALL win.
REQ-033 The internal phase counter SHALL be at least 16 bits, SHALL reload on each state entry, and SHALL never wrap within a phase.

Reset
REQ-034 reset=1 SHALL immediately force IDLE.
REQ-035 During and after reset, cnt_clr, cnt_en, busy, done, resp_bit, tie and sat SHALL be 0 and margin SHALL be 0.
REQ-036 Reset asserted mid-measurement SHALL drop cnt_en asynchronously, with no done pulse.

Verification
REQ-037 Use WINDOW_CYCLES=8, CLR_CYCLES=2, SETTLE_CYCLES=4; start pulse on edge 0; cnt_a=300, cnt_b=250 -> cnt_clr high cycles 1-2; cnt_en high cycles 3-10; done high in cycle 16 only; resp_bit=1, margin=50, tie=0, sat=0.
REQ-038 Run with cnt_a=250, cnt_b=300, then with cnt_a=cnt_b=777 -> first run gives resp_bit=0, margin=50; second run gives resp_bit=0, tie=1, margin=0.
REQ-039 Run with cnt_a=4095, cnt_b=10 -> sat=1, resp_bit=1, margin=4085.
REQ-040 Pulse abort in COUNT cycle 5 -> cnt_en low next cycle; busy=0; no done pulse; previous results unchanged; the next start runs a full-length measurement.
REQ-041 Assert reset in SETTLE -> all outputs 0 immediately, including without a clock edge; start after reset release behaves as in REQ-037.
REQ-042 Hold start high continuously -> back-to-back measurements, each beginning the cycle after DONE; start pulses while busy are ignored.

Source files
------------

// File: rtl/puf_measure_ctrl.sv
// Ring-oscillator PUF measurement sequencer: clears and gates two RO counters,
// then compares the frozen counts into a response bit, margin, tie and saturation flag.
module puf_measure_ctrl #(
  parameter int CNT_W         = 12,
  parameter int CLR_CYCLES    = 2,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic             resp_bit,
  output logic [CNT_W-1:0] margin,
  output logic             tie,
  output logic             sat
);

  localparam logic [15:0] CLR_LOAD    = 16'(CLR_CYCLES - 1);
  localparam logic [15:0] WINDOW_LOAD = 16'(WINDOW_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_COUNT   = 3'd2,
    S_SETTLE  = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] x,
                                                input logic [CNT_W-1:0] y);
    return (x > y) ? (x - y) : (y - x);
  endfunction

  state_t           r_state;
  logic [15:0]      r_phase;
  logic             r_cnt_clr;
  logic             r_cnt_en;
  logic             r_busy;
  logic             r_done;
  logic             r_resp_bit;
  logic [CNT_W-1:0] r_margin;
  logic             r_tie;
  logic             r_sat;

  logic             w_a_gt_b;
  logic             w_a_eq_b;
  logic             w_sat;
  logic [CNT_W-1:0] w_margin;

  assign w_a_gt_b = (cnt_a > cnt_b);
  assign w_a_eq_b = (cnt_a == cnt_b);
  assign w_sat    = (cnt_a == CNT_MAX) || (cnt_b == CNT_MAX);
  assign w_margin = abs_diff(cnt_a, cnt_b);

  // Sequencer: phase counter reloads on every state entry and counts down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_phase    <= 16'd0;
      r_cnt_clr  <= 1'b0;
      r_cnt_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_resp_bit <= 1'b0;
      r_margin   <= '0;
      r_tie      <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_CLEAR;
            r_phase   <= CLR_LOAD;
            r_cnt_clr <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_cnt_clr <= 1'b0;
            r_cnt_en  <= 1'b0;
            r_busy    <= 1'b0;
          end else if (r_phase == 16'd0) begin
            r_state   <= S_COUNT;
            r_phase   <= WINDOW_LOAD;
            r_cnt_clr <= 1'b0;
            r_cnt_en  <= 1'b1;
          end else begin
            r_phase <= r_phase - 16'd1;
          end
        end
        S_COUNT: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_cnt_clr <= 1'b0;
            r_cnt_en  <= 1'b0;
            r_busy    <= 1'b0;
          end else if (r_phase == 16'd0) begin
            r_state  <= S_SETTLE;
            r_phase  <= SETTLE_LOAD;
            r_cnt_en <= 1'b0;
          end else begin
            r_phase <= r_phase - 16'd1;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_cnt_clr <= 1'b0;
            r_cnt_en  <= 1'b0;
            r_busy    <= 1'b0;
          end else if (r_phase == 16'd0) begin
            r_state <= S_COMPARE;
            r_phase <= 16'd0;
          end else begin
            r_phase <= r_phase - 16'd1;
          end
        end
        S_COMPARE: begin
          // Counters are frozen by now; the result registers are the latch.
          r_state    <= S_DONE;
          r_done     <= 1'b1;
          r_resp_bit <= w_a_gt_b;
          r_margin   <= w_margin;
          r_tie      <= w_a_eq_b;
          r_sat      <= w_sat;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_phase   <= 16'd0;
          r_cnt_clr <= 1'b0;
          r_cnt_en  <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_clr  = r_cnt_clr;
  assign cnt_en   = r_cnt_en;
  assign busy     = r_busy;
  assign done     = r_done;
  assign resp_bit = r_resp_bit;
  assign margin   = r_margin;
  assign tie      = r_tie;
  assign sat      = r_sat;

endmodule

// File: tb/tb_puf_measure_ctrl.sv
// Directed + randomized bench for puf_measure_ctrl against a cycle-schedule
// and arithmetic reference model.
module tb_puf_measure_ctrl;
  localparam int CW    = 12;
  localparam int CLR   = 2;
  localparam int WIN   = 8;
  localparam int SET   = 4;
  localparam int TOTAL = CLR + WIN + SET + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic          cnt_clr;
  logic          cnt_en;
  logic          busy;
  logic          done;
  logic          resp_bit;
  logic [CW-1:0] margin;
  logic          tie;
  logic          sat;

  puf_measure_ctrl #(
    .CNT_W(CW), .CLR_CYCLES(CLR), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
    .busy(busy), .done(done), .resp_bit(resp_bit), .margin(margin),
    .tie(tie), .sat(sat)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int exp_resp   = 0;
  int exp_margin = 0;
  int exp_tie    = 0;
  int exp_sat    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_results(input string tag);
    chk({tag, ".resp_bit"}, 32'(resp_bit), 32'(exp_resp));
    chk({tag, ".margin"},   32'(margin),   32'(exp_margin));
    chk({tag, ".tie"},      32'(tie),      32'(exp_tie));
    chk({tag, ".sat"},      32'(sat),      32'(exp_sat));
  endtask

  // Expected control outputs in cycle k after the start edge.
  task automatic chk_ctrl(input string tag, input int k);
    chk({tag, ".cnt_clr"}, 32'(cnt_clr), 32'(k >= 1 && k <= CLR));
    chk({tag, ".cnt_en"},  32'(cnt_en),  32'(k > CLR && k <= CLR + WIN));
    chk({tag, ".busy"},    32'(busy),    32'(k >= 1 && k <= TOTAL));
    chk({tag, ".done"},    32'(done),    32'(k == TOTAL));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".cnt_clr"}, 32'(cnt_clr), 32'd0);
    chk({tag, ".cnt_en"},  32'(cnt_en),  32'd0);
    chk({tag, ".busy"},    32'(busy),    32'd0);
    chk({tag, ".done"},    32'(done),    32'd0);
  endtask

  task automatic model_update(input int a, input int b);
    exp_resp   = (a > b) ? 1 : 0;
    exp_tie    = (a == b) ? 1 : 0;
    exp_margin = (a > b) ? (a - b) : (b - a);
    exp_sat    = (a == (1 << CW) - 1 || b == (1 << CW) - 1) ? 1 : 0;
  endtask

  task automatic measure(input int a, input int b, input bit hold_start);
    @(negedge clk);
    chk_idle("pre");
    chk_results("pre");
    start = 1'b1;
    abort = 1'($urandom_range(0, 1));
    cnt_a = CW'($urandom);
    cnt_b = CW'($urandom);
    for (int k = 1; k <= TOTAL; k++) begin
      @(negedge clk);
      chk_ctrl($sformatf("meas.k%0d", k), k);
      if (k == TOTAL) model_update(a, b);
      chk_results($sformatf("meas.k%0d", k));
      if (hold_start) start = 1'b1;
      else if (k < TOTAL) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      abort = (k >= TOTAL - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k >= CLR + WIN) begin
        cnt_a = CW'(a);
        cnt_b = CW'(b);
      end else begin
        cnt_a = CW'($urandom);
        cnt_b = CW'($urandom);
      end
    end
  endtask

  task automatic abort_run(input int abort_k);
    @(negedge clk);
    chk_idle("abpre");
    start = 1'b1;
    abort = 1'b0;
    for (int k = 1; k <= TOTAL + 2; k++) begin
      @(negedge clk);
      if (k <= abort_k) chk_ctrl($sformatf("abort%0d.k%0d", abort_k, k), k);
      else chk_idle($sformatf("abort%0d.k%0d", abort_k, k));
      chk_results($sformatf("abort%0d.k%0d", abort_k, k));
      start = 1'b0;
      abort = (k == abort_k) ? 1'b1 : 1'b0;
      cnt_a = CW'($urandom);
      cnt_b = CW'($urandom);
    end
    abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cnt_a = '0;
    cnt_b = '0;
    #1;
    chk_idle("reset");
    chk_results("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    measure(300, 250, 1'b0);
    measure(250, 300, 1'b0);
    measure(777, 777, 1'b0);
    measure(4095, 10, 1'b0);
    abort_run(CLR + 5);
    measure(1000, 1001, 1'b0);
    abort_run(1);
    abort_run(CLR + WIN + SET);
    abort_run($urandom_range(1, CLR + WIN + SET));
    measure(4095, 4095, 1'b0);

    for (int i = 0; i < 3; i++) measure($urandom_range(0, 4095), $urandom_range(0, 4095), 1'b1);
    for (int i = 0; i < 4; i++) measure($urandom_range(0, 4095), $urandom_range(0, 4095), 1'b0);

    // Reset in the middle of SETTLE, checked between clock edges.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    for (int k = 1; k <= CLR + WIN + 2; k++) begin
      @(negedge clk);
      chk_ctrl($sformatf("prerst.k%0d", k), k);
      start = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    exp_resp = 0; exp_margin = 0; exp_tie = 0; exp_sat = 0;
    chk_idle("async_rst");
    chk_results("async_rst");
    @(negedge clk);
    chk_idle("in_rst");
    reset = 1'b0;
    measure(300, 250, 1'b0);

    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_idle("tail");
      chk_results("tail");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
